// File: rtl/eei.sv
// Environment-level constants shared by the membus slaves: widths, memory map
// and the ACLINT register decode helpers.
package eei;
  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;

  typedef logic [XLEN-1:0] Addr;
  typedef logic [63:0]     UInt64;

  localparam Addr MMAP_ACLINT_BEGIN    = 64'h0000_0000_0200_0000;
  localparam Addr MMAP_ACLINT_MSIP     = MMAP_ACLINT_BEGIN + 64'h0000;
  localparam Addr MMAP_ACLINT_MTIMECMP = MMAP_ACLINT_BEGIN + 64'h4000;
  localparam Addr MMAP_ACLINT_MTIME    = MMAP_ACLINT_BEGIN + 64'h7ff8;
  localparam Addr MMAP_ACLINT_SETSSIP  = MMAP_ACLINT_BEGIN + 64'h8000;
  localparam Addr MMAP_ACLINT_END      = MMAP_ACLINT_BEGIN + 64'hffff;

  localparam UInt64 MTIMECMP_RESET = '1;

  typedef enum logic [1:0] {ACL_MSIP, ACL_MTIMECMP, ACL_MTIME, ACL_SETSSIP} AclintReg;

  typedef struct packed {
    logic     none;
    AclintReg sel;
  } AclintDecode;

  // Word index within the window; the low three address bits are don't-care.
  function automatic logic [12:0] aclint_word(Addr addr);
    return 13'((addr - MMAP_ACLINT_BEGIN) >> 3);
  endfunction

  function automatic AclintDecode aclint_decode(Addr addr);
    AclintDecode d;
    logic [12:0] w;
    w = aclint_word(addr);
    d = '{none: 1'b1, sel: ACL_MSIP};
    if (w == aclint_word(MMAP_ACLINT_MSIP))     d = '{none: 1'b0, sel: ACL_MSIP};
    if (w == aclint_word(MMAP_ACLINT_MTIMECMP)) d = '{none: 1'b0, sel: ACL_MTIMECMP};
    if (w == aclint_word(MMAP_ACLINT_MTIME))    d = '{none: 1'b0, sel: ACL_MTIME};
    if (w == aclint_word(MMAP_ACLINT_SETSSIP))  d = '{none: 1'b0, sel: ACL_SETSSIP};
    return d;
  endfunction

  function automatic UInt64 byte_merge(UInt64 old, UInt64 wdata, logic [7:0] wmask);
    UInt64 m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{wmask[i]}};
    return (old & ~m) | (wdata & m);
  endfunction
endpackage

// File: rtl/aclint_memory_if.sv
// Membus request/response bundle between the address decoder and the ACLINT.
interface aclint_memory_if;
  import eei::*;

  logic                           valid;
  logic                           ready;
  Addr                            addr;
  logic                           wen;
  logic [MEMBUS_DATA_WIDTH-1:0]   wdata;
  logic [MEMBUS_DATA_WIDTH/8-1:0] wmask;
  logic                           rvalid;
  logic [MEMBUS_DATA_WIDTH-1:0]   rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/mtime_counter.sv
// Prescaled 64-bit free-running time base with a software load port.
module mtime_counter
  import eei::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  UInt64 i_load_val,
  output UInt64 o_mtime,
  output UInt64 o_mtime_next
);
  localparam logic [15:0] PRE_LAST = 16'(MTIME_DIV - 1);

  logic [15:0] r_pre;
  UInt64       r_mtime;
  logic        w_wrap;
  UInt64       w_next;

  assign w_wrap = (r_pre == PRE_LAST);

  // A load takes priority over the tick; the prescaler keeps running regardless.
  always_comb begin
    w_next = r_mtime;
    if (i_load)      w_next = i_load_val;
    else if (w_wrap) w_next = r_mtime + 64'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_mtime <= '0;
    end else begin
      r_pre   <= w_wrap ? '0 : r_pre + 16'd1;
      r_mtime <= w_next;
    end
  end

  assign o_mtime      = r_mtime;
  assign o_mtime_next = w_next;
endmodule

// File: rtl/aclint_memory.sv
// Single-hart ACLINT membus slave: MSIP, MTIMECMP, MTIME and SETSSIP registers
// with interrupt outputs to the CSR unit.
module aclint_memory
  import eei::*;
#(
  parameter int unsigned MTIME_DIV  = 1,
  parameter int          DATA_WIDTH = MEMBUS_DATA_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  aclint_memory_if.slave membus,
  output logic         o_msip,
  output logic         o_mtip,
  output logic         o_setssip,
  output UInt64        o_mtime
);
  logic                  r_ready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_msip;
  UInt64                 r_mtimecmp;
  logic                  r_mtip;
  logic                  r_setssip;

  logic        w_acc;
  logic        w_wr;
  AclintDecode w_dec;
  logic        w_load;
  UInt64       w_mtime;
  UInt64       w_mtime_next;
  UInt64       w_cmp_next;
  UInt64       w_rd;

  assign w_acc  = membus.valid & r_ready;
  assign w_dec  = aclint_decode(membus.addr);
  assign w_wr   = w_acc & membus.wen & ~w_dec.none;
  // An all-zero mask writes nothing, so it must not suppress the tick.
  assign w_load = w_wr & (w_dec.sel == ACL_MTIME) & (|membus.wmask);

  assign w_cmp_next = (w_wr && w_dec.sel == ACL_MTIMECMP)
                    ? byte_merge(r_mtimecmp, membus.wdata, membus.wmask)
                    : r_mtimecmp;

  always_comb begin
    w_rd = '0;
    if (!w_dec.none) begin
      case (w_dec.sel)
        ACL_MSIP:     w_rd = {63'b0, r_msip};
        ACL_MTIMECMP: w_rd = r_mtimecmp;
        ACL_MTIME:    w_rd = w_mtime;
        default:      w_rd = '0;
      endcase
    end
  end

  mtime_counter #(.MTIME_DIV(MTIME_DIV)) u_mtime (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_load_val  (byte_merge(w_mtime, membus.wdata, membus.wmask)),
    .o_mtime     (w_mtime),
    .o_mtime_next(w_mtime_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_msip     <= 1'b0;
      r_mtimecmp <= MTIMECMP_RESET;
      r_mtip     <= 1'b0;
      r_setssip  <= 1'b0;
    end else begin
      r_ready    <= 1'b1;
      r_rvalid   <= w_acc;
      r_rdata    <= (w_acc && !membus.wen) ? w_rd : '0;
      if (w_wr && w_dec.sel == ACL_MSIP && membus.wmask[0]) r_msip <= membus.wdata[0];
      r_mtimecmp <= w_cmp_next;
      // Compare next-state values so a write is reflected one cycle after acceptance.
      r_mtip     <= (w_mtime_next >= w_cmp_next);
      r_setssip  <= w_wr & (w_dec.sel == ACL_SETSSIP) & membus.wmask[0] & membus.wdata[0];
    end
  end

  assign membus.ready  = r_ready;
  assign membus.rvalid = r_rvalid;
  assign membus.rdata  = r_rdata;
  assign o_msip        = r_msip;
  assign o_mtip        = r_mtip;
  assign o_setssip     = r_setssip;
  assign o_mtime       = w_mtime;
endmodule

// File: tb/tb_aclint_memory.sv
// Self-checking bench for aclint_memory: directed vector table, hand sequences
// and randomized traffic against a register-level reference model.
module tb_aclint_memory;
  import eei::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aclint_memory_if bus();
  aclint_memory_if bus4();

  logic  msip, mtip, setssip, msip4, mtip4, setssip4;
  UInt64 mtime, mtime4;

  aclint_memory #(.MTIME_DIV(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .membus(bus),
    .o_msip(msip), .o_mtip(mtip), .o_setssip(setssip), .o_mtime(mtime)
  );

  aclint_memory #(.MTIME_DIV(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .membus(bus4),
    .o_msip(msip4), .o_mtip(mtip4), .o_setssip(setssip4), .o_mtime(mtime4)
  );

  int total = 0;
  int bad   = 0;

  UInt64 m_mtime, m_cmp, m_rdata;
  logic  m_msip, m_ready, m_setssip, m_rvalid;

  task automatic check64(input string name, input UInt64 act, input UInt64 exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic UInt64 merge_ref(UInt64 old, UInt64 wd, logic [7:0] m);
    UInt64 r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = 0; m_cmp = '1; m_msip = 0; m_ready = 0;
    m_setssip = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  // Register-level view: what each register holds after the current clock edge.
  task automatic model_step();
    logic  acc;
    UInt64 word, nm, nc, rd;
    logic  ns, nss;
    acc  = bus.valid && m_ready;
    word = (bus.addr - MMAP_ACLINT_BEGIN) & 64'hfff8;
    nm = m_mtime + 1; nc = m_cmp; ns = m_msip; nss = 0; rd = 0;
    if (acc && !bus.wen) begin
      case (word)
        64'h0000: rd = {63'b0, m_msip};
        64'h4000: rd = m_cmp;
        64'h7ff8: rd = m_mtime;
        default:  rd = 0;
      endcase
    end
    if (acc && bus.wen) begin
      case (word)
        64'h0000: if (bus.wmask[0]) ns = bus.wdata[0];
        64'h4000: nc = merge_ref(m_cmp, bus.wdata, bus.wmask);
        64'h7ff8: if (bus.wmask != 0) nm = merge_ref(m_mtime, bus.wdata, bus.wmask);
        64'h8000: nss = bus.wmask[0] & bus.wdata[0];
        default: ;
      endcase
    end
    m_mtime = nm; m_cmp = nc; m_msip = ns; m_setssip = nss;
    m_rvalid = acc; m_rdata = rd; m_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check64("ready", 64'(bus.ready), 64'(m_ready));
    check64("rvalid", 64'(bus.rvalid), 64'(m_rvalid));
    if (m_rvalid) check64("rdata", bus.rdata, m_rdata);
    check64("mtime", mtime, m_mtime);
    check64("mtip", 64'(mtip), 64'(m_mtime >= m_cmp));
    check64("msip", 64'(msip), 64'(m_msip));
    check64("setssip", 64'(setssip), 64'(m_setssip));
  endtask

  task automatic drive(input logic [15:0] off, input logic wen, input UInt64 wd, input logic [7:0] wm);
    bus.valid = 1; bus.wen = wen; bus.wdata = wd; bus.wmask = wm;
    bus.addr  = MMAP_ACLINT_BEGIN + {48'b0, off} + 64'($urandom_range(0, 7));
  endtask

  task automatic idle();
    bus.valid = 0; bus.wen = 0; bus.wdata = 0; bus.wmask = 0;
  endtask

  task automatic do_op(input logic [15:0] off, input logic wen, input UInt64 wd,
                       input logic [7:0] wm, output UInt64 rd);
    drive(off, wen, wd, wm);
    tick();
    idle();
    rd = bus.rdata;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    idle();
    model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  typedef struct {
    logic [15:0] off;
    logic        wen;
    UInt64       wdata;
    logic [7:0]  wmask;
    logic        chk;
    UInt64       exp;
  } vec_t;

  vec_t  vecs[$];
  UInt64 rd, e;
  int    n;

  initial begin
    idle();
    bus.addr = MMAP_ACLINT_BEGIN;
    bus4.valid = 0; bus4.addr = MMAP_ACLINT_BEGIN; bus4.wen = 0;
    bus4.wdata = 0; bus4.wmask = 0;

    vecs.push_back('{16'h0000, 1, 64'hFFFF_FFFF, 8'hFF, 0, 0});
    vecs.push_back('{16'h0000, 0, 0, 0, 1, 64'h1});
    vecs.push_back('{16'h8000, 0, 0, 0, 1, 64'h0});
    vecs.push_back('{16'h1000, 0, 0, 0, 1, 64'h0});
    vecs.push_back('{16'h4000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{16'h4000, 1, 64'h1234, 8'h01, 0, 0});
    vecs.push_back('{16'h4000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF34});
    vecs.push_back('{16'h0000, 1, 64'h0, 8'hFE, 0, 0});
    vecs.push_back('{16'h0000, 0, 0, 0, 1, 64'h1});
    vecs.push_back('{16'h0000, 1, 64'h0, 8'h01, 0, 0});
    vecs.push_back('{16'h0000, 0, 0, 0, 1, 64'h0});
    vecs.push_back('{16'h1000, 1, 64'hFFFF, 8'hFF, 0, 0});
    vecs.push_back('{16'h4000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF34});
    vecs.push_back('{16'h4000, 1, '1, 8'hFF, 0, 0});

    // Reset state, idle counting, and the divide-by-4 prescaler.
    model_reset();
    tick(); tick();
    check64("rst_rvalid", 64'(bus.rvalid), 0);
    check64("rst_mtip", 64'(mtip), 0);
    rst_n = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check64("div4_mtime", mtime4, UInt64'(i / 4));
    end
    do_op(16'h7ff8, 0, 0, 0, rd);
    check64("reset_mtime_read", rd, 64'd10);
    do_op(16'h4000, 0, 0, 0, rd);
    check64("reset_mtimecmp_read", rd, '1);

    foreach (vecs[i]) begin
      do_op(vecs[i].off, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, rd);
      if (vecs[i].chk) check64($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Timer interrupt threshold.
    reset_dut();
    tick();
    do_op(16'h4000, 1, 64'h40, 8'hFF, rd);
    n = 0;
    while (mtime < 64'h3f && n < 200) begin tick(); n++; end
    check64("mtip_wait_bound", 64'(n < 200), 1);
    check64("mtip_below", 64'(mtip), 0);
    tick();
    check64("mtime_at_cmp", mtime, 64'h40);
    check64("mtip_at_cmp", 64'(mtip), 1);
    do_op(16'h4000, 1, '1, 8'hFF, rd);
    check64("mtip_cleared", 64'(mtip), 0);

    // Byte-masked MTIME writes.
    reset_dut();
    tick();
    do_op(16'h7ff8, 1, 64'h1122_3344_5566_7788, 8'h0F, rd);
    check64("mask_write", mtime, 64'h5566_7788);
    tick();
    check64("mask_count", mtime, 64'h5566_7789);
    do_op(16'h7ff8, 1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, rd);
    check64("mask_zero", mtime, 64'h5566_778A);

    // Supervisor software interrupt pulse.
    do_op(16'h8000, 1, 64'h1, 8'h01, rd);
    check64("setssip_pulse", 64'(setssip), 1);
    tick();
    check64("setssip_single", 64'(setssip), 0);
    do_op(16'h8000, 1, 64'h0, 8'hFF, rd);
    check64("setssip_zero", 64'(setssip), 0);

    // Write colliding with an increment, then wrap.
    do_op(16'h7ff8, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
    check64("collide_write", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check64("collide_next", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check64("wrap_zero", mtime, 64'h0);

    // Back-to-back reads: unmapped then MTIME.
    drive(16'h1000, 0, 0, 0);
    tick();
    check64("b2b_rvalid0", 64'(bus.rvalid), 1);
    check64("b2b_rdata0", bus.rdata, 0);
    e = mtime;
    drive(16'h7ff8, 0, 0, 0);
    tick();
    idle();
    check64("b2b_rvalid1", 64'(bus.rvalid), 1);
    check64("b2b_rdata1", bus.rdata, e);
    tick();

    // Reset right after acceptance drops the response.
    drive(16'h0000, 0, 0, 0);
    @(posedge clk);
    rst_n = 0;
    #1;
    check64("rst_mid_rvalid", 64'(bus.rvalid), 0);
    idle();
    model_reset();
    tick();
    rst_n = 1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        logic [15:0] off;
        UInt64 wd;
        case ($urandom_range(0, 4))
          0: off = 16'h0000;
          1: off = 16'h4000;
          2: off = 16'h7ff8;
          3: off = 16'h8000;
          default: off = 16'($urandom_range(0, 16'hffff));
        endcase
        wd = {32'h0, 32'($urandom)};
        if (off == 16'h4000) wd = mtime + 64'($urandom_range(0, 8));
        if (off == 16'h7ff8 && $urandom_range(0, 1) == 1) wd = m_cmp - 64'($urandom_range(0, 4));
        drive(off, 1'($urandom_range(0, 1)), wd,
              ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      end
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
